// File: rtl/nibble_parity_pkg.sv
// nibble_parity_pkg
//   Shared definitions for the nibble parity checker and the generator-side
//   bench model.
//   - NIB_W, DP_W : data nibble width and protected word width.
//   - state_e     : checker lock FSM states.
//   - parity_of() : even parity over the data bits selected by the mask.
package nibble_parity_pkg;

  localparam int unsigned NIB_W = 4;
  localparam int unsigned DP_W  = 5;

  typedef enum logic [1:0] {
    StRun,
    StSuspect,
    StLock
  } state_e;

  // XOR of the masked data bits, seeded with 0. An all-zero mask yields 0.
  function automatic logic parity_of(input logic [NIB_W-1:0] d,
                                     input logic [NIB_W-1:0] en);
    return ^(d & en);
  endfunction

endpackage

// File: rtl/nibble_skid_fifo.sv
// nibble_skid_fifo
//   Two-entry valid/ready FIFO. in_ready is derived from registered state
//   only, so it never combinationally depends on out_ready or in_valid.
//   Ports:
//     clk       in   clock, rising edge
//     rst       in   synchronous active-high reset, empties the FIFO
//     in_valid  in   write request
//     in_ready  out  FIFO has a free entry
//     in_data   in   entry payload
//     out_valid out  head entry is valid
//     out_ready in   downstream consumes head entry
//     out_data  out  head entry payload (zero after reset)
module nibble_skid_fifo #(
  parameter int unsigned Width = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [Width-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [Width-1:0] out_data
);

  logic [Width-1:0] mem_q [2];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       count_q;
  logic             push;
  logic             pop;

  assign in_ready  = (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign out_data  = mem_q[rd_ptr_q];

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= in_data;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      // Push and pop together leave the occupancy unchanged.
      count_q <= count_q + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: rtl/nibble_parity_checker.sv
// nibble_parity_checker
//   Receive-side parity checker for 5-bit protected words {P, D[3:0]}.
//   Recomputes masked even parity, queues {perr, q} in a 2-entry FIFO,
//   counts errored words (saturating) and locks the input after ERR_LIMIT
//   consecutive errored words until clr_cnt or rst.
//   Parameters:
//     CNT_W     width of the saturating error counter
//     ERR_LIMIT consecutive errored words that force lock (1..15)
//   Ports:
//     clk       in   clock, rising edge
//     rst       in   synchronous active-high reset
//     in_valid  in   dp/en valid
//     in_ready  out  checker accepts a word
//     dp        in   protected word, [3:0] data, [4] parity
//     en        in   parity bit-mask used by the sender
//     out_valid out  q/perr hold a checked word
//     out_ready in   downstream consumes the word
//     q         out  checked data nibble
//     perr      out  parity mismatch for the word on q
//     err_cnt   out  errored words accepted, saturating
//     fault     out  high while locked
//     clr_cnt   in   clears err_cnt, consecutive count and lock
module nibble_parity_checker
  import nibble_parity_pkg::*;
#(
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned ERR_LIMIT = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DP_W-1:0]  dp,
  input  logic [NIB_W-1:0] en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [NIB_W-1:0] q,
  output logic             perr,
  output logic [CNT_W-1:0] err_cnt,
  output logic             fault,
  input  logic             clr_cnt
);

  localparam logic [3:0]       Limit  = 4'(ERR_LIMIT);
  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

  state_e           state_q;
  logic [3:0]       consec_q;
  logic [3:0]       consec_inc;
  logic [CNT_W-1:0] err_cnt_q;
  logic             fault_q;

  logic             fifo_in_ready;
  logic             accept;
  logic             perr_in;
  logic [DP_W-1:0]  fifo_out_data;

  assign perr_in = parity_of(dp[NIB_W-1:0], en) ^ dp[DP_W-1];

  // rst is folded in so the port reads 0 during every reset cycle, even
  // once the registers already hold their reset values.
  assign in_ready = fifo_in_ready && (state_q != StLock) && !rst;
  assign accept   = in_valid && in_ready;

  nibble_skid_fifo #(
    .Width(DP_W)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .in_valid (accept),
    .in_ready (fifo_in_ready),
    .in_data  ({perr_in, dp[NIB_W-1:0]}),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (fifo_out_data)
  );

  assign q       = fifo_out_data[NIB_W-1:0];
  assign perr    = fifo_out_data[DP_W-1];
  assign err_cnt = err_cnt_q;
  assign fault   = fault_q;

  assign consec_inc = consec_q + 4'd1;

  // Lock FSM, error counter and fault flag. clr_cnt overrides any update
  // from a word accepted in the same cycle; that word is still queued.
  always_ff @(posedge clk) begin
    if (rst || clr_cnt) begin
      state_q   <= StRun;
      consec_q  <= 4'd0;
      err_cnt_q <= '0;
      fault_q   <= 1'b0;
    end else if (accept) begin
      if (perr_in) begin
        if (err_cnt_q != CntMax) begin
          err_cnt_q <= err_cnt_q + CNT_W'(1);
        end
        case (state_q)
          StRun: begin
            consec_q <= 4'd1;
            if (Limit == 4'd1) begin
              state_q <= StLock;
              fault_q <= 1'b1;
            end else begin
              state_q <= StSuspect;
            end
          end
          StSuspect: begin
            consec_q <= consec_inc;
            if (consec_inc >= Limit) begin
              state_q <= StLock;
              fault_q <= 1'b1;
            end
          end
          default: begin
            // No accepts happen in lock.
          end
        endcase
      end else begin
        state_q  <= StRun;
        consec_q <= 4'd0;
      end
    end
  end

endmodule

// File: tb/tb_nibble_parity_checker.sv
// Directed bench for nibble_parity_checker. Inputs change 1 time unit after
// the rising edge; outputs are sampled on the falling edge.
module tb_nibble_parity_checker;
  import nibble_parity_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready, out_valid, out_ready, perr, fault, clr_cnt;
  logic [4:0] dp;
  logic [3:0] en, q;
  logic [7:0] err_cnt;

  // Second instance with a 2-bit counter for saturation.
  logic       b_in_valid, b_in_ready, b_out_valid, b_perr, b_fault;
  logic [4:0] b_dp;
  logic [3:0] b_q;
  logic [1:0] b_err_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  nibble_parity_checker #(.CNT_W(8), .ERR_LIMIT(3)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .dp(dp), .en(en),
    .out_valid(out_valid), .out_ready(out_ready), .q(q), .perr(perr), .err_cnt(err_cnt),
    .fault(fault), .clr_cnt(clr_cnt)
  );

  nibble_parity_checker #(.CNT_W(2), .ERR_LIMIT(3)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .dp(b_dp),
    .en(4'hF), .out_valid(b_out_valid), .out_ready(1'b1), .q(b_q), .perr(b_perr),
    .err_cnt(b_err_cnt), .fault(b_fault), .clr_cnt(1'b0)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; clr_cnt = 1'b0; dp = '0; en = '0;
    b_in_valid = 1'b0; b_dp = '0;

    // Reset
    @(negedge clk);
    check_eq("rst_in_ready", 32'(in_ready), 32'd0);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_q", 32'(q), 32'd0);
    check_eq("rst_perr", 32'(perr), 32'd0);
    check_eq("rst_err_cnt", 32'(err_cnt), 32'd0);
    check_eq("rst_fault", 32'(fault), 32'd0);
    tick(); rst = 1'b0;
    @(negedge clk);
    check_eq("rst_release_ready", 32'(in_ready), 32'd1);

    // Clean stream: 0x03 -> data 3 P0 clean, 0x17 -> data 7 P1 clean
    tick(); out_ready = 1'b1; in_valid = 1'b1; dp = 5'h03; en = 4'hF;
    @(negedge clk);
    check_eq("clean_ready", 32'(in_ready), 32'd1);
    check_eq("clean_empty", 32'(out_valid), 32'd0);
    tick(); dp = 5'h17;
    @(negedge clk);
    check_eq("clean_lat_valid", 32'(out_valid), 32'd1);
    check_eq("clean_q0", 32'(q), 32'h3);
    check_eq("clean_perr0", 32'(perr), 32'd0);
    tick(); in_valid = 1'b0;
    @(negedge clk);
    check_eq("clean_q1", 32'(q), 32'h7);
    check_eq("clean_perr1", 32'(perr), 32'd0);
    tick();
    @(negedge clk);
    check_eq("clean_drained", 32'(out_valid), 32'd0);
    check_eq("clean_err_cnt", 32'(err_cnt), 32'd0);

    // Masked parity on 0x1D (data 1101, P=1):
    // EN=0101 -> bits0,2 = 1^1 = 0, mismatch; EN=1111 -> 1^0^1^1 = 1, clean
    tick(); in_valid = 1'b1; dp = 5'h1D; en = 4'h5;
    tick(); en = 4'hF;
    @(negedge clk);
    check_eq("mask_q", 32'(q), 32'hD);
    check_eq("mask_0101_perr", 32'(perr), 32'd1);
    tick(); in_valid = 1'b0;
    @(negedge clk);
    check_eq("mask_1111_perr", 32'(perr), 32'd0);
    check_eq("mask_err_cnt", 32'(err_cnt), 32'd1);
    tick(); clr_cnt = 1'b1;
    tick(); clr_cnt = 1'b0;
    @(negedge clk);
    check_eq("clr_err_cnt", 32'(err_cnt), 32'd0);

    // Backpressure: three clean words with out_ready low
    tick(); out_ready = 1'b0; in_valid = 1'b1; dp = 5'h03; en = 4'hF;
    tick(); dp = 5'h17;
    @(negedge clk);
    check_eq("bp_ready1", 32'(in_ready), 32'd1);
    check_eq("bp_q_first", 32'(q), 32'h3);
    tick(); dp = 5'h05;
    @(negedge clk);
    check_eq("bp_full_ready", 32'(in_ready), 32'd0);
    check_eq("bp_hold_q", 32'(q), 32'h3);
    tick(); out_ready = 1'b1;
    @(negedge clk);
    check_eq("bp_still_full", 32'(in_ready), 32'd0);
    check_eq("bp_hold_q2", 32'(q), 32'h3);
    tick();
    @(negedge clk);
    check_eq("bp_q_second", 32'(q), 32'h7);
    check_eq("bp_ready_occ1", 32'(in_ready), 32'd1);
    tick(); in_valid = 1'b0;
    @(negedge clk);
    check_eq("bp_q_third", 32'(q), 32'h5);
    check_eq("bp_pushpop_occ1", 32'(in_ready), 32'd1);
    check_eq("bp_third_valid", 32'(out_valid), 32'd1);
    tick();
    @(negedge clk);
    check_eq("bp_drained", 32'(out_valid), 32'd0);

    // Lock: 0x01 errored (data 1, P=0), 0x00 clean; sequence e c e e e
    tick(); in_valid = 1'b1; dp = 5'h01;
    tick(); dp = 5'h00;
    @(negedge clk);
    check_eq("lock_st1", 32'(dut.state_q), 32'(StSuspect));
    check_eq("lock_cnt1", 32'(err_cnt), 32'd1);
    tick(); dp = 5'h01;
    @(negedge clk);
    check_eq("lock_st2", 32'(dut.state_q), 32'(StRun));
    tick();
    @(negedge clk);
    check_eq("lock_st3", 32'(dut.state_q), 32'(StSuspect));
    tick();
    @(negedge clk);
    check_eq("lock_st4", 32'(dut.state_q), 32'(StSuspect));
    check_eq("lock_fault4", 32'(fault), 32'd0);
    check_eq("lock_ready4", 32'(in_ready), 32'd1);
    tick();
    @(negedge clk);
    check_eq("lock_st5", 32'(dut.state_q), 32'(StLock));
    check_eq("lock_fault", 32'(fault), 32'd1);
    check_eq("lock_ready", 32'(in_ready), 32'd0);
    check_eq("lock_err_cnt", 32'(err_cnt), 32'd4);
    check_eq("lock_drain_valid", 32'(out_valid), 32'd1);
    check_eq("lock_drain_perr", 32'(perr), 32'd1);
    tick();
    @(negedge clk);
    check_eq("lock_drained", 32'(out_valid), 32'd0);
    check_eq("lock_no_accept", 32'(err_cnt), 32'd4);

    // Clear out of lock
    tick(); in_valid = 1'b0; clr_cnt = 1'b1;
    tick(); clr_cnt = 1'b0;
    @(negedge clk);
    check_eq("clr_fault", 32'(fault), 32'd0);
    check_eq("clr_cnt_zero", 32'(err_cnt), 32'd0);
    check_eq("clr_ready", 32'(in_ready), 32'd1);
    // clr_cnt together with an errored accept
    tick(); in_valid = 1'b1; dp = 5'h01; clr_cnt = 1'b1;
    tick(); in_valid = 1'b0; clr_cnt = 1'b0;
    @(negedge clk);
    check_eq("clr_word_valid", 32'(out_valid), 32'd1);
    check_eq("clr_word_q", 32'(q), 32'h1);
    check_eq("clr_word_perr", 32'(perr), 32'd1);
    check_eq("clr_word_uncounted", 32'(err_cnt), 32'd0);
    check_eq("clr_word_state", 32'(dut.state_q), 32'(StRun));
    tick();

    // Saturation on 2-bit counter: e c e c e c e c e (five errors, no lock)
    for (int i = 0; i < 9; i++) begin
      tick(); b_in_valid = 1'b1; b_dp = (i % 2 == 0) ? 5'h01 : 5'h00;
      @(negedge clk);
      if (i == 4) check_eq("sat_cnt2", 32'(b_err_cnt), 32'd2);
      if (i == 6) check_eq("sat_cnt3", 32'(b_err_cnt), 32'd3);
    end
    tick(); b_in_valid = 1'b0;
    @(negedge clk);
    check_eq("sat_stick", 32'(b_err_cnt), 32'd3);
    check_eq("sat_no_fault", 32'(b_fault), 32'd0);

    // Reset with two errored words queued
    tick(); out_ready = 1'b0; in_valid = 1'b1; dp = 5'h01;
    tick();
    tick(); in_valid = 1'b0;
    @(negedge clk);
    check_eq("prerst_err_cnt", 32'(err_cnt), 32'd2);
    check_eq("prerst_full", 32'(in_ready), 32'd0);
    tick(); rst = 1'b1;
    @(negedge clk);
    check_eq("midrst_ready", 32'(in_ready), 32'd0);
    tick(); rst = 1'b0;
    @(negedge clk);
    check_eq("postrst_valid", 32'(out_valid), 32'd0);
    check_eq("postrst_err_cnt", 32'(err_cnt), 32'd0);
    check_eq("postrst_ready", 32'(in_ready), 32'd1);
    check_eq("postrst_q", 32'(q), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

endmodule
